gray_tracker: RTL

- Downstream consumer of the 3-bit Gray up-counter; samples its code output on a strobe.
- Converts each sample to binary and checks that every change is a legal single-bit Gray step.
- Reports step direction, counts forward wraps (7->0), and latches an error on any illegal jump.
- Gives the surrounding datapath a verified binary count position plus a wrap count.

---
 rtl/gray_tracker.sv | 109 ++++++++++
 1 files changed

// File: rtl/gray_tracker.sv
// Tracks a 3-bit Gray up/down counter. Each sampled code is checked as a legal single-bit step.
// Reports the binary position, the direction of the last step, and a saturating forward-wrap count.
module gray_tracker #(
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        Gray,
  input  logic              Sample,
  input  logic              Clear,
  output logic [2:0]        Bin,
  output logic              Dir,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Locked,
  output logic              Err
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [WRAP_W-1:0] WRAPS_MAX = {WRAP_W{1'b1}};

  function automatic logic [2:0] conv(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic [2:0]        bin_q, bin_d;
  logic              dir_q, dir_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  logic [2:0] new_bin;
  logic [2:0] step;

  assign new_bin = conv(Gray);
  // The step is measured against the last accepted code, so an illegal jump never moves the reference.
  assign step    = new_bin - conv(prev_q);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    bin_d   = bin_q;
    dir_d   = dir_q;
    wraps_d = wraps_q;
    if (Clear) begin
      state_d = UNLOCKED;
      prev_d  = 3'd0;
      bin_d   = 3'd0;
      dir_d   = 1'b0;
      wraps_d = '0;
    end else if (Sample) begin
      case (state_q)
        UNLOCKED: begin
          prev_d  = Gray;
          bin_d   = new_bin;
          state_d = LOCKED;
        end
        LOCKED: begin
          if (step == 3'd1) begin
            prev_d = Gray;
            bin_d  = new_bin;
            dir_d  = 1'b1;
            if (bin_q == 3'd7 && wraps_q != WRAPS_MAX) begin
              wraps_d = wraps_q + WRAP_W'(1);
            end
          end else if (step == 3'd7) begin
            prev_d = Gray;
            bin_d  = new_bin;
            dir_d  = 1'b0;
          end else if (step != 3'd0) begin
            state_d = ERROR;
          end
        end
        default: state_d = ERROR;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= UNLOCKED;
      prev_q  <= 3'd0;
      bin_q   <= 3'd0;
      dir_q   <= 1'b0;
      wraps_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      dir_q   <= dir_d;
      wraps_q <= wraps_d;
    end
  end

  assign Bin    = bin_q;
  assign Dir    = dir_q;
  assign Wraps  = wraps_q;
  assign Locked = (state_q == LOCKED);
  assign Err    = (state_q == ERROR);

endmodule
